// File: rtl/btb_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
package btb_pkg;

    localparam logic [1:0] CTR_INIT = 2'b10;
    localparam logic [1:0] CTR_MAX  = 2'b11;
    localparam logic [1:0] CTR_MIN  = 2'b00;

    typedef enum logic {BTB_IDLE, BTB_FLUSH} btb_state_e;

    // Way-index width; never zero so a 1-way BTB still has a usable port.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Replacement victim picker for one set: first invalid way, else first way with nru=0.
module btb_victim_sel
    import btb_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WW  = way_w(WAYS)
) (
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] nru,
    output logic [WW-1:0]   victim,
    output logic            all_valid
);

    // Scan downward so the lowest qualifying index is the last assignment; invalid ways take precedence.
    always_comb begin
        victim    = '0;
        all_valid = &valid;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!nru[w]) victim = WW'(w);
        if (!all_valid)
            for (int w = WAYS - 1; w >= 0; w--)
                if (!valid[w]) victim = WW'(w);
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational lookup, EX-driven update with NRU allocation, sequenced flush.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int WAYS       = 2,
    parameter int TAG_BITS   = 20,
    localparam int SETS      = 1 << INDEX_BITS,
    localparam int WW        = way_w(WAYS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INDEX_BITS-1:0] pc_index,
    input  logic [TAG_BITS-1:0]   pc_tag,
    output logic                  hit,
    output logic [WW-1:0]         hit_way,
    output logic                  predict_taken,
    output logic [31:0]           target_out,
    input  logic                  update_en,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic [TAG_BITS-1:0]   update_tag,
    input  logic [31:0]           update_target,
    input  logic                  update_taken,
    input  logic                  flush,
    output logic                  busy
);

    // Only valid/nru carry reset; payload arrays are don't-care until allocated.
    logic [SETS-1:0][WAYS-1:0] valid_q, nru_q;
    logic [TAG_BITS-1:0]       tag_q [SETS][WAYS];
    logic [31:0]               tgt_q [SETS][WAYS];
    logic [1:0]                ctr_q [SETS][WAYS];

    btb_state_e            state;
    logic [INDEX_BITS-1:0] cnt;

    logic            u_hit, u_all_valid, u_do;
    logic [WW-1:0]   u_hit_way, u_victim, u_way;
    logic [WAYS-1:0] u_onehot, u_nru_next;
    logic [1:0]      u_ctr_next;

    assign busy = (state == BTB_FLUSH);

    // Lookup: lowest matching valid way wins; everything forced quiet during the sweep.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        predict_taken = 1'b0;
        target_out    = 32'h0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (valid_q[pc_index][w] && tag_q[pc_index][w] == pc_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        if (busy) begin
            hit     = 1'b0;
            hit_way = '0;
        end
        if (hit) begin
            predict_taken = ctr_q[pc_index][hit_way][1];
            target_out    = tgt_q[pc_index][hit_way];
        end
    end

    // Update-side tag match in the update set.
    always_comb begin
        u_hit     = 1'b0;
        u_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (valid_q[update_index][w] && tag_q[update_index][w] == update_tag) begin
                u_hit     = 1'b1;
                u_hit_way = WW'(w);
            end
    end

    btb_victim_sel #(.WAYS(WAYS)) u_vsel (
        .valid     (valid_q[update_index]),
        .nru       (nru_q[update_index]),
        .victim    (u_victim),
        .all_valid (u_all_valid)
    );

    // Write way, aged NRU vector and next counter value for the update set.
    always_comb begin
        u_do       = update_en && !busy && (u_hit || update_taken);
        u_way      = u_hit ? u_hit_way : u_victim;
        u_onehot   = '0;
        u_onehot[u_way] = 1'b1;
        u_nru_next = nru_q[update_index] | u_onehot;
        if (&u_nru_next) u_nru_next = u_onehot;
        if (!u_hit)
            u_ctr_next = CTR_INIT;
        else if (update_taken)
            u_ctr_next = (ctr_q[update_index][u_way] == CTR_MAX) ? CTR_MAX : ctr_q[update_index][u_way] + 2'd1;
        else
            u_ctr_next = (ctr_q[update_index][u_way] == CTR_MIN) ? CTR_MIN : ctr_q[update_index][u_way] - 2'd1;
    end

    // Control state: FSM, flush counter, valid and nru bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= BTB_IDLE;
            cnt     <= '0;
            valid_q <= '0;
            nru_q   <= '0;
        end else begin
            case (state)
                BTB_IDLE: begin
                    if (u_do) begin
                        valid_q[update_index][u_way] <= 1'b1;
                        nru_q[update_index]          <= u_nru_next;
                    end
                    if (flush) begin
                        state <= BTB_FLUSH;
                        cnt   <= '0;
                    end
                end
                default: begin
                    valid_q[cnt] <= '0;
                    nru_q[cnt]   <= '0;
                    cnt          <= cnt + 1'b1;
                    if (&cnt) state <= BTB_IDLE;
                end
            endcase
        end
    end

    // Payload write for hits and allocations.
    always_ff @(posedge clk) begin
        if (u_do) begin
            tag_q[update_index][u_way] <= update_tag;
            tgt_q[update_index][u_way] <= update_target;
            ctr_q[update_index][u_way] <= u_ctr_next;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with a queued-expectation scoreboard.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  pc_index;
    logic [19:0] pc_tag;
    logic        hit;
    logic [0:0]  hit_way;
    logic        predict_taken;
    logic [31:0] target_out;
    logic        update_en;
    logic [5:0]  update_index;
    logic [19:0] update_tag;
    logic [31:0] update_target;
    logic        update_taken;
    logic        flush;
    logic        busy;

    btb_assoc #(.INDEX_BITS(6), .WAYS(2), .TAG_BITS(20)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_index      (pc_index),
        .pc_tag        (pc_tag),
        .hit           (hit),
        .hit_way       (hit_way),
        .predict_taken (predict_taken),
        .target_out    (target_out),
        .update_en     (update_en),
        .update_index  (update_index),
        .update_tag    (update_tag),
        .update_target (update_target),
        .update_taken  (update_taken),
        .flush         (flush),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hit;
        logic [0:0]  way;
        logic        pt;
        logic [31:0] tgt;
        logic        busy;
    } exp_t;

    exp_t q[$];
    logic chk_en = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    // Monitor: whenever a checked lookup is presented, pop and compare.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_lookup: no expectation queued");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (hit !== e.hit || hit_way !== e.way || predict_taken !== e.pt ||
                    target_out !== e.tgt || busy !== e.busy) begin
                    n_err++;
                    $display("FAIL %s: got hit=%b way=%0d pt=%b tgt=%h busy=%b, want hit=%b way=%0d pt=%b tgt=%h busy=%b",
                             e.name, hit, hit_way, predict_taken, target_out, busy,
                             e.hit, e.way, e.pt, e.tgt, e.busy);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [5:0] idx, input logic [19:0] tag,
                       input logic [31:0] tgt, input logic taken);
        update_en     = 1'b1;
        update_index  = idx;
        update_tag    = tag;
        update_target = tgt;
        update_taken  = taken;
        tick();
        update_en = 1'b0;
    endtask

    // Present a lookup for one cycle and queue its expected response.
    task automatic look(input string nm, input logic [5:0] idx, input logic [19:0] tag,
                        input logic eh, input logic [0:0] ew, input logic ep,
                        input logic [31:0] et, input logic eb);
        exp_t e;
        e.name = nm; e.hit = eh; e.way = ew; e.pt = ep; e.tgt = et; e.busy = eb;
        q.push_back(e);
        pc_index = idx;
        pc_tag   = tag;
        chk_en   = 1'b1;
        tick();
        chk_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; pc_index = '0; pc_tag = '0; update_en = 1'b0;
        update_index = '0; update_tag = '0; update_target = '0; update_taken = 1'b0;
        flush = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        look("reset_lookup", 6'd5, 20'h123, 0, 0, 0, 32'h0, 0);

        // Allocate and walk the direction counter down.
        upd(6'd5, 20'h123, 32'h400, 1'b1);
        look("alloc_hit", 6'd5, 20'h123, 1, 0, 1, 32'h400, 0);
        upd(6'd5, 20'h123, 32'h400, 1'b0);
        look("ctr1", 6'd5, 20'h123, 1, 0, 0, 32'h400, 0);
        upd(6'd5, 20'h123, 32'h400, 1'b0);
        look("ctr0", 6'd5, 20'h123, 1, 0, 0, 32'h400, 0);
        upd(6'd5, 20'h123, 32'h400, 1'b0);
        look("ctr_sat_low", 6'd5, 20'h123, 1, 0, 0, 32'h400, 0);

        // NRU replacement in set 3.
        upd(6'd3, 20'hA, 32'h1000, 1'b1);
        upd(6'd3, 20'hB, 32'h2000, 1'b1);
        upd(6'd3, 20'hC, 32'h3000, 1'b1);
        look("A_evicted", 6'd3, 20'hA, 0, 0, 0, 32'h0, 0);
        look("C_way0", 6'd3, 20'hC, 1, 0, 1, 32'h3000, 0);
        look("B_way1", 6'd3, 20'hB, 1, 1, 1, 32'h2000, 0);
        upd(6'd3, 20'hB, 32'h2222, 1'b1);
        upd(6'd3, 20'hD, 32'h4000, 1'b1);
        look("C_evicted", 6'd3, 20'hC, 0, 0, 0, 32'h0, 0);
        look("D_way0", 6'd3, 20'hD, 1, 0, 1, 32'h4000, 0);
        look("B_retarget", 6'd3, 20'hB, 1, 1, 1, 32'h2222, 0);

        // Not-taken miss never allocates.
        upd(6'd9, 20'h77, 32'h5000, 1'b0);
        look("nt_no_alloc", 6'd9, 20'h77, 0, 0, 0, 32'h0, 0);

        // Fill more sets, then flush with a same-cycle update and a mid-sweep update.
        upd(6'd10, 20'h10, 32'h6000, 1'b1);
        upd(6'd11, 20'h11, 32'h7000, 1'b1);
        look("pre_flush", 6'd11, 20'h11, 1, 0, 1, 32'h7000, 0);
        flush = 1'b1;
        upd(6'd13, 20'h66, 32'h8000, 1'b1);
        flush = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 20) begin
                update_en = 1'b1; update_index = 6'd12; update_tag = 20'h55;
                update_target = 32'h9000; update_taken = 1'b1;
            end
            look("flush_busy", (i[0] ? 6'd11 : 6'd5), (i[0] ? 20'h11 : 20'h123), 0, 0, 0, 32'h0, 1);
            update_en = 1'b0;
        end
        look("post_flush_5", 6'd5, 20'h123, 0, 0, 0, 32'h0, 0);
        look("post_flush_3", 6'd3, 20'hD, 0, 0, 0, 32'h0, 0);
        look("post_flush_11", 6'd11, 20'h11, 0, 0, 0, 32'h0, 0);
        look("midflush_upd", 6'd12, 20'h55, 0, 0, 0, 32'h0, 0);
        look("flush_same_cyc", 6'd13, 20'h66, 0, 0, 0, 32'h0, 0);

        // Reset in the middle of a sweep, before set 40 is reached.
        upd(6'd40, 20'h99, 32'hA000, 1'b1);
        look("set40_hit", 6'd40, 20'h99, 1, 0, 1, 32'hA000, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (10) look("flush2_busy", 6'd40, 20'h99, 0, 0, 0, 32'h0, 1);
        reset_n = 1'b0;
        #1;
        look("reset_midflush", 6'd40, 20'h99, 0, 0, 0, 32'h0, 0);
        reset_n = 1'b1;
        tick();
        look("after_reset", 6'd40, 20'h99, 0, 0, 0, 32'h0, 0);
        upd(6'd40, 20'h99, 32'h800, 1'b1);
        look("realloc", 6'd40, 20'h99, 1, 0, 1, 32'h800, 0);

        repeat (2) tick();
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expectations: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
